// File: rtl/ica_pkg.sv
// ica_pkg: shared definitions for the FastICA iteration controller.
//   state_t   - controller state encoding (4-bit)
//   width_of  - index width for a count of n items (never below 1 bit)
//   IDX_W     - component index width at the default component count
//   IT_W      - iteration counter width at the default iteration limit
package ica_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_ACCUM = 4'd2,
        S_DIV   = 4'd3,
        S_ORTH  = 4'd4,
        S_NORM  = 4'd5,
        S_CHECK = 4'd6,
        S_WRITE = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    // A single item still needs one bit to carry an index of 0.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_N_COMP   = 2;
    localparam int DEF_MAX_ITER = 32;
    localparam int IDX_W        = width_of(DEF_N_COMP);
    localparam int IT_W         = width_of(DEF_MAX_ITER);

endpackage

// File: rtl/ica_step_counter.sv
// ica_step_counter: loadable up-counter with a terminal-count compare.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - synchronous load of load_val (wins over inc)
//   load_val   - value taken on load
//   inc        - count up by one; ignored once cnt has reached term
//   term       - terminal value
//   cnt        - current count (registered)
//   at_term    - cnt == term
module ica_step_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    assign at_term = (cnt == term);

    // Increment is gated at the terminal value so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && !at_term) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ica_iteration_controller.sv
// ica_iteration_controller: sequences the FastICA fixed-point iteration.
// Per component: accumulate over the whitened samples in mem3, scale,
// deflate against earlier components, normalise, check convergence, and
// loop until converged or MAX_ITER is reached; then write W.
//   CLK_ICA     - block clock
//   GO_ica      - asynchronous active-low reset / enable
//   Whiten_done - whitened data valid (looked at only in IDLE)
//   norm_done   - normaliser completion pulse
//   conv_ok     - convergence flag, sampled in CHECK
//   ICA_busy    - INIT..WRITE       ICA_done - in DONE
//   En_mem3/z_addr - mem3 read      En_upd   - update accumulator enable
//   GO_div      - scale pulse       GO_orth/orth_idx - deflation step
//   GO_norm     - normaliser start  En_wmem  - W memory write
//   comp_idx, iter_cnt - progress   nonconv  - per-component limit flag
module ica_iteration_controller
    import ica_pkg::*;
#(
    parameter int N_SAMPLES = 128,
    parameter int N_COMP    = 2,
    parameter int MAX_ITER  = 32,
    parameter int CNT_W     = 8
) (
    input  logic                          CLK_ICA,
    input  logic                          GO_ica,
    input  logic                          Whiten_done,
    input  logic                          norm_done,
    input  logic                          conv_ok,
    output logic                          ICA_busy,
    output logic                          ICA_done,
    output logic                          En_mem3,
    output logic [CNT_W-1:0]              z_addr,
    output logic                          En_upd,
    output logic                          GO_div,
    output logic                          GO_orth,
    output logic [width_of(N_COMP)-1:0]   orth_idx,
    output logic                          GO_norm,
    output logic                          En_wmem,
    output logic [width_of(N_COMP)-1:0]   comp_idx,
    output logic [width_of(MAX_ITER)-1:0] iter_cnt,
    output logic [N_COMP-1:0]             nonconv
);

    localparam int CW = width_of(N_COMP);
    localparam int IW = width_of(MAX_ITER);

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(N_SAMPLES - 1);
    localparam logic [CW-1:0]    LAST_COMP   = CW'(N_COMP - 1);
    localparam logic [IW-1:0]    LAST_ITER   = IW'(MAX_ITER - 1);

    state_t           state;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] step_term;
    logic             step_hit;
    logic             step_clr;
    logic             step_inc;
    logic             iter_hit;
    logic             iter_clr;
    logic             iter_inc;

    // The step counter is shared: sample index in ACCUM, deflation index
    // in ORTH. ORTH is only reached with comp_idx >= 1, so comp_idx-1
    // never underflows.
    always_comb begin
        step_term = LAST_SAMPLE;
        if (state == S_ORTH) begin
            step_term = CNT_W'(comp_idx) - 1'b1;
        end
    end

    always_comb begin
        step_clr = 1'b0;
        step_inc = 1'b0;
        iter_clr = 1'b0;
        iter_inc = 1'b0;
        case (state)
            S_IDLE:  iter_clr = Whiten_done;
            S_INIT: begin
                step_clr = 1'b1;
                iter_clr = 1'b1;
            end
            S_ACCUM, S_ORTH: begin
                step_clr = step_hit;
                step_inc = !step_hit;
            end
            S_CHECK: iter_inc = !conv_ok && !iter_hit;
            // Clearing on the way into INIT makes iter_cnt read 0 in INIT.
            S_WRITE: iter_clr = (comp_idx != LAST_COMP);
            default: ;
        endcase
    end

    ica_step_counter #(.W(CNT_W)) u_step (
        .clk      (CLK_ICA),
        .rst_n    (GO_ica),
        .load     (step_clr),
        .load_val ('0),
        .inc      (step_inc),
        .term     (step_term),
        .cnt      (step_cnt),
        .at_term  (step_hit)
    );

    ica_step_counter #(.W(IW)) u_iter (
        .clk      (CLK_ICA),
        .rst_n    (GO_ica),
        .load     (iter_clr),
        .load_val ('0),
        .inc      (iter_inc),
        .term     (LAST_ITER),
        .cnt      (iter_cnt),
        .at_term  (iter_hit)
    );

    // Outputs are computed for the state being entered, so each enable
    // is high exactly during the cycles spent in its state.
    always_ff @(posedge CLK_ICA or negedge GO_ica) begin
        if (!GO_ica) begin
            state    <= S_IDLE;
            ICA_busy <= 1'b0;
            ICA_done <= 1'b0;
            En_mem3  <= 1'b0;
            z_addr   <= '0;
            En_upd   <= 1'b0;
            GO_div   <= 1'b0;
            GO_orth  <= 1'b0;
            orth_idx <= '0;
            GO_norm  <= 1'b0;
            En_wmem  <= 1'b0;
            comp_idx <= '0;
            nonconv  <= '0;
        end else begin
            En_mem3  <= 1'b0;
            z_addr   <= '0;
            En_upd   <= 1'b0;
            GO_div   <= 1'b0;
            GO_orth  <= 1'b0;
            orth_idx <= '0;
            GO_norm  <= 1'b0;
            En_wmem  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Whiten_done) begin
                        state    <= S_INIT;
                        ICA_busy <= 1'b1;
                    end
                end
                S_INIT: begin
                    state   <= S_ACCUM;
                    En_mem3 <= 1'b1;
                    En_upd  <= 1'b1;
                end
                S_ACCUM: begin
                    if (step_hit) begin
                        state  <= S_DIV;
                        GO_div <= 1'b1;
                    end else begin
                        En_mem3 <= 1'b1;
                        En_upd  <= 1'b1;
                        z_addr  <= step_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (comp_idx == '0) begin
                        state   <= S_NORM;
                        GO_norm <= 1'b1;
                    end else begin
                        state   <= S_ORTH;
                        GO_orth <= 1'b1;
                    end
                end
                S_ORTH: begin
                    if (step_hit) begin
                        state   <= S_NORM;
                        GO_norm <= 1'b1;
                    end else begin
                        GO_orth  <= 1'b1;
                        orth_idx <= CW'(step_cnt + 1'b1);
                    end
                end
                S_NORM: begin
                    // GO_norm still high marks the first NORM cycle; a
                    // done pulse coinciding with the start is stale.
                    if (!GO_norm && norm_done) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (conv_ok) begin
                        state   <= S_WRITE;
                        En_wmem <= 1'b1;
                    end else if (iter_hit) begin
                        state             <= S_WRITE;
                        En_wmem           <= 1'b1;
                        nonconv[comp_idx] <= 1'b1;
                    end else begin
                        state   <= S_ACCUM;
                        En_mem3 <= 1'b1;
                        En_upd  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (comp_idx == LAST_COMP) begin
                        state    <= S_DONE;
                        ICA_done <= 1'b1;
                        ICA_busy <= 1'b0;
                    end else begin
                        state    <= S_INIT;
                        comp_idx <= comp_idx + 1'b1;
                    end
                end
                S_DONE:  ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ica_iteration_controller.sv
module tb_ica_iteration_controller;
    import ica_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic go = 1'b0, go4 = 1'b0, wd = 1'b0, nd = 1'b0, cok = 1'b0;

    // default-parameter instance
    logic             busy, done, en_mem3, en_upd, go_div, go_orth, go_norm, en_wmem;
    logic [7:0]       z_addr;
    logic [IDX_W-1:0] orth_idx, comp_idx;
    logic [IT_W-1:0]  iter_cnt;
    logic [1:0]       nonconv;

    // four-component instance (short accumulation pass)
    logic       busy4, done4, en_mem34, en_upd4, go_div4, go_orth4, go_norm4, en_wmem4;
    logic [7:0] z_addr4;
    logic [1:0] orth_idx4, comp_idx4, iter_cnt4;
    logic [3:0] nonconv4;

    int checks = 0;
    int errors = 0;

    logic [24:0] all_out;
    assign all_out = {busy, done, en_mem3, z_addr, en_upd, go_div, go_orth, orth_idx,
                      go_norm, en_wmem, comp_idx, iter_cnt, nonconv};

    ica_iteration_controller dut (
        .CLK_ICA(clk), .GO_ica(go), .Whiten_done(wd), .norm_done(nd), .conv_ok(cok),
        .ICA_busy(busy), .ICA_done(done), .En_mem3(en_mem3), .z_addr(z_addr),
        .En_upd(en_upd), .GO_div(go_div), .GO_orth(go_orth), .orth_idx(orth_idx),
        .GO_norm(go_norm), .En_wmem(en_wmem), .comp_idx(comp_idx),
        .iter_cnt(iter_cnt), .nonconv(nonconv)
    );

    ica_iteration_controller #(.N_SAMPLES(16), .N_COMP(4), .MAX_ITER(4), .CNT_W(8)) dut4 (
        .CLK_ICA(clk), .GO_ica(go4), .Whiten_done(wd), .norm_done(nd), .conv_ok(cok),
        .ICA_busy(busy4), .ICA_done(done4), .En_mem3(en_mem34), .z_addr(z_addr4),
        .En_upd(en_upd4), .GO_div(go_div4), .GO_orth(go_orth4), .orth_idx(orth_idx4),
        .GO_norm(go_norm4), .En_wmem(en_wmem4), .comp_idx(comp_idx4),
        .iter_cnt(iter_cnt4), .nonconv(nonconv4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Advance one cycle and sample at the falling edge; the datapath
    // enables of both instances must be one-hot-or-idle every cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("onehot", 32'($onehot0({en_upd, go_div, go_orth, go_norm, en_wmem})), 32'd1);
        chk("onehot4", 32'($onehot0({en_upd4, go_div4, go_orth4, go_norm4, en_wmem4})), 32'd1);
    endtask

    // Entered at the first ACCUM cycle; returns at the cycle after CHECK.
    task automatic do_iter(input int comp, input int it, input int nd_delay,
                           input bit conv, input bit full, input bit early);
        cok = conv;
        for (int k = 0; k < 128; k++) begin
            if (full || k == 0 || k == 127)
                chk("accum", {en_mem3, en_upd, z_addr, iter_cnt, comp_idx,
                              go_div, go_orth, go_norm, en_wmem},
                    {2'b11, 8'(k), 5'(it), 1'(comp), 4'b0000});
            tick();
        end
        chk("div", {go_div, en_upd, go_orth, go_norm}, 4'b1000);
        tick();
        for (int j = 0; j < comp; j++) begin
            chk("orth", {go_orth, orth_idx, go_div, go_norm}, {1'b1, 1'(j), 2'b00});
            tick();
        end
        chk("norm_start", {go_norm, go_orth, en_upd}, 3'b100);
        if (early) nd = 1'b1;
        for (int j = 1; j < nd_delay; j++) begin
            tick();
            nd = 1'b0;
            chk("norm_wait", {go_norm, en_wmem, en_upd, go_orth, busy}, 5'b00001);
        end
        tick();
        nd = 1'b1;
        tick();
        nd = 1'b0;
        chk("check", {go_norm, en_wmem, en_upd, busy}, 4'b0001);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int orth_cnt[4];
        logic pend;

        // ---- reset state ----
        tick();
        tick();
        chk("reset_all", 32'(all_out), 32'd0);

        // ---- idle while Whiten_done is low ----
        go = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle", 32'(all_out), 32'd0);
        end
        wd = 1'b1;
        tick();
        chk("init0", {busy, done, en_upd, en_wmem, comp_idx, iter_cnt, z_addr},
            {4'b1000, 1'b0, 5'd0, 8'd0});
        wd = 1'b0;                          // later deassertion is ignored
        tick();

        // ---- converging run: comp 0 full check, comp 1 early norm pulse ----
        do_iter(0, 0, 3, 1'b1, 1'b1, 1'b0);
        chk("write0", {en_wmem, comp_idx, busy, done}, 4'b1010);
        tick();
        chk("init1", {busy, en_wmem, en_upd, comp_idx, iter_cnt}, {3'b100, 1'b1, 5'd0});
        tick();
        do_iter(1, 0, 5, 1'b1, 1'b1, 1'b1);
        chk("write1", {en_wmem, comp_idx, busy}, 3'b111);
        tick();
        chk("done_conv", {done, busy, en_wmem, en_upd, nonconv}, 6'b100000);
        wd = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("done_hold", {done, busy, comp_idx}, 3'b101);

        // ---- never converging: each component hits the iteration limit ----
        go = 1'b0;
        tick();
        chk("reset_again", 32'(all_out), 32'd0);
        go = 1'b1;
        tick();
        wd = 1'b0;
        chk("init_nc", {busy, comp_idx, iter_cnt}, {1'b1, 1'b0, 5'd0});
        tick();
        for (int c = 0; c < 2; c++) begin
            for (int it = 0; it < 32; it++) do_iter(c, it, 2, 1'b0, 1'b0, 1'b0);
            chk("write_nc", {en_wmem, iter_cnt, nonconv},
                {1'b1, 5'd31, (c == 0) ? 2'b01 : 2'b11});
            tick();
            if (c == 0) begin
                chk("init_nc1", {busy, comp_idx, iter_cnt}, {1'b1, 1'b1, 5'd0});
                tick();
            end
        end
        chk("done_nc", {done, busy, nonconv}, 4'b1011);

        // ---- reset in the middle of comp 1 accumulation ----
        go = 1'b0;
        tick();
        go = 1'b1;
        wd = 1'b1;
        tick();
        wd = 1'b0;
        tick();
        do_iter(0, 0, 2, 1'b1, 1'b0, 1'b0);
        tick();                             // WRITE -> INIT
        tick();                             // INIT -> ACCUM
        for (int k = 0; k < 60; k++) tick();
        chk("mid_accum", {en_upd, comp_idx, z_addr}, {1'b1, 1'b1, 8'd60});
        go = 1'b0;
        #1;
        chk("mid_reset", 32'(all_out), 32'd0);
        @(negedge clk);
        go = 1'b1;
        wd = 1'b1;
        tick();
        chk("restart_init", {busy, comp_idx, en_upd}, 3'b100);
        tick();
        chk("restart_accum", {en_upd, comp_idx, z_addr}, {1'b1, 1'b0, 8'd0});

        // ---- four components: deflation index sequence per component ----
        go = 1'b0;
        cok = 1'b1;
        nd = 1'b0;
        tick();
        go4 = 1'b1;
        pend = 1'b0;
        for (int c = 0; c < 4; c++) orth_cnt[c] = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            nd = pend;
            pend = go_norm4;
            if (go_orth4) begin
                chk("orth4_idx", 32'(orth_idx4), 32'(orth_cnt[comp_idx4]));
                orth_cnt[comp_idx4]++;
            end
            if (done4) break;
        end
        nd = 1'b0;
        chk("done4", {done4, busy4, nonconv4}, 6'b100000);
        for (int c = 0; c < 4; c++) chk("orth4_count", 32'(orth_cnt[c]), 32'(c));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
